// File: rtl/taus_urng.sv
// rtl/taus_urng.sv - taus88 uniform RNG feeding the Box-Muller core; TAUS_URNG_SAMPLE_CNT_EN adds sample_cnt
module taus_urng #(
  parameter int unsigned WARMUP_STEPS = 16,
  parameter logic [31:0] SEED3_XOR    = 32'h9E3779B9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed1,
  input  logic [31:0] seed2,
  input  logic        load,
  input  logic        u_ready,
  output logic        u_valid,
  output logic [47:0] u0,
  output logic [15:0] u1,
  output logic        busy
`ifdef TAUS_URNG_SAMPLE_CNT_EN
  ,
  output logic [31:0] sample_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, WARM, GEN_A, GEN_B, OUT} state_t;

  localparam logic [7:0] WARM_LAST = 8'(WARMUP_STEPS - 1);

  state_t      state, state_nxt;
  logic [31:0] s1, s2, s3;
  logic [31:0] b1, b2, b3;
  logic [31:0] s1_nxt, s2_nxt, s3_nxt;
  logic [31:0] word;
  logic [31:0] hi;
  logic [7:0]  warm_cnt;
  logic        step;
  logic        handshake;

  // u_valid is exactly "sitting in OUT", so it cannot drop without a handshake, load or reset
  assign u_valid   = (state == OUT);
  assign busy      = (state == WARM);
  assign handshake = u_valid && u_ready;

  // One taus88 step of all three component generators, combined into the output word
  always_comb begin
    b1     = ((s1 << 13) ^ s1) >> 19;
    s1_nxt = ((s1 & 32'hFFFFFFFE) << 12) ^ b1;
    b2     = ((s2 << 2) ^ s2) >> 25;
    s2_nxt = ((s2 & 32'hFFFFFFF8) << 4) ^ b2;
    b3     = ((s3 << 3) ^ s3) >> 11;
    s3_nxt = ((s3 & 32'hFFFFFFF0) << 17) ^ b3;
    word   = s1_nxt ^ s2_nxt ^ s3_nxt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and step enable; a load restarts from any state and beats a handshake
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      IDLE:  state_nxt = IDLE;
      WARM: begin
        step = 1'b1;
        if (warm_cnt == WARM_LAST) state_nxt = GEN_A;
      end
      GEN_A: begin
        step      = 1'b1;
        state_nxt = GEN_B;
      end
      GEN_B: begin
        step      = 1'b1;
        state_nxt = OUT;
      end
      OUT:     if (handshake) state_nxt = GEN_A;
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      state_nxt = WARM;
      step      = 1'b0;
    end
  end

  // Generator state, warm-up counter and sample registers; u0/u1 only move on entry to OUT
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      hi       <= '0;
      u0       <= '0;
      u1       <= '0;
      warm_cnt <= '0;
    end else if (load) begin
      s1       <= seed1 | 32'h2;
      s2       <= seed2 | 32'h8;
      s3       <= (seed1 ^ seed2 ^ SEED3_XOR) | 32'h10;
      warm_cnt <= '0;
    end else begin
      if (step) begin
        s1 <= s1_nxt;
        s2 <= s2_nxt;
        s3 <= s3_nxt;
      end
      if (state == WARM) warm_cnt <= warm_cnt + 8'd1;
      if (state == GEN_A) hi <= word;
      if (state == GEN_B) begin
        u0 <= {hi, word[31:16]};
        u1 <= word[15:0];
      end
    end
  end

`ifdef TAUS_URNG_SAMPLE_CNT_EN
  // Completed handshakes since the last load or reset, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset || load) sample_cnt <= '0;
    else if (handshake) sample_cnt <= sample_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_taus_urng.sv
// tb/tb_taus_urng.sv - directed self-checking bench for taus_urng against a taus88 reference
module tb_taus_urng;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seed1;
  logic [31:0] seed2;
  logic        load;
  logic        u_ready;
  logic        u_valid;
  logic [47:0] u0;
  logic [15:0] u1;
  logic        busy;
`ifdef TAUS_URNG_SAMPLE_CNT_EN
  logic [31:0] sample_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] m1, m2, m3;

  taus_urng dut (
    .clk(clk),
    .reset(reset),
    .seed1(seed1),
    .seed2(seed2),
    .load(load),
    .u_ready(u_ready),
    .u_valid(u_valid),
    .u0(u0),
    .u1(u1),
    .busy(busy)
`ifdef TAUS_URNG_SAMPLE_CNT_EN
    ,
    .sample_cnt(sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference taus88 step, written straight from the C recurrence
  task automatic m_step(output logic [31:0] w);
    logic [31:0] b;
    b  = ((m1 << 13) ^ m1) >> 19;
    m1 = ((m1 & 32'hFFFFFFFE) << 12) ^ b;
    b  = ((m2 << 2) ^ m2) >> 25;
    m2 = ((m2 & 32'hFFFFFFF8) << 4) ^ b;
    b  = ((m3 << 3) ^ m3) >> 11;
    m3 = ((m3 & 32'hFFFFFFF0) << 17) ^ b;
    w  = m1 ^ m2 ^ m3;
  endtask

  task automatic m_load(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] dummy;
    m1 = a | 32'h2;
    m2 = b | 32'h8;
    m3 = (a ^ b ^ 32'h9E3779B9) | 32'h10;
    for (int i = 0; i < 16; i++) m_step(dummy);
  endtask

  task automatic m_sample(output logic [63:0] s);
    logic [31:0] wa, wb;
    m_step(wa);
    m_step(wb);
    s = {wa, wb};
  endtask

  // Pulse load for one cycle; returns one cycle after the load edge
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    seed1 = a;
    seed2 = b;
    load  = 1'b1;
    m_load(a, b);
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!u_valid && n < 64) begin
      tick();
      n++;
    end
  endtask

  // Compare the presented sample to the model, then let it be consumed and measure the gap
  task automatic run_samples(input string tag, input int cnt);
    logic [63:0] exp;
    int gap;
    for (int i = 0; i < cnt; i++) begin
      m_sample(exp);
      chk(tag, {u0, u1}, exp);
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!u_valid && gap < 10);
      chk({tag, "_gap"}, 64'(gap), 64'd3);
    end
  endtask

  initial begin
    int n;
    logic [63:0] exp;

    // Reset dominates a simultaneous load
    reset   = 1'b1;
    load    = 1'b1;
    seed1   = 32'hA5A5A5A5;
    seed2   = 32'h5A5A5A5A;
    u_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 64'(u_valid), 64'd0);
      chk("rst_u", {u0, u1}, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    reset = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_valid", 64'(u_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_s1", 64'(dut.s1), 64'd0);

    // Golden sequence: warm-up timing, then 100 samples at one per 3 cycles
    u_ready = 1'b1;
    start(32'h00067580, 32'h00070385);
    chk("gold_valid_low", 64'(u_valid), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      chk("gold_busy", 64'(busy), 64'd1);
      tick();
    end
    chk("gold_busy_fall", 64'(busy), 64'd0);
    chk("gold_valid_17", 64'(u_valid), 64'd0);
    tick();
    chk("gold_valid_18", 64'(u_valid), 64'd0);
    tick();
    chk("gold_valid_19", 64'(u_valid), 64'd1);
    run_samples("gold", 100);

    // Seed clamp: all-zero seeds get the minimum bits forced on
    start(32'h0, 32'h0);
    chk("clamp_s1", 64'(dut.s1), 64'h2);
    chk("clamp_s2", 64'(dut.s2), 64'h8);
    chk("clamp_s3", 64'(dut.s3), 64'h9E3779B9);
    wait_valid(n);
    chk("clamp_latency", 64'(n), 64'd18);
    chk("clamp_nonzero", 64'({u0, u1} != 64'd0), 64'd1);
    run_samples("clamp", 10);

    // Backpressure: sample and generator state frozen while u_ready is low
    u_ready = 1'b0;
    start(32'h12345678, 32'hCAFEF00D);
    wait_valid(n);
    chk("bp_latency", 64'(n), 64'd18);
    m_sample(exp);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", {u0, u1}, exp);
      chk("bp_valid", 64'(u_valid), 64'd1);
      chk("bp_s1s2", {dut.s1, dut.s2}, {m1, m2});
      tick();
    end
    chk("bp_s3", 64'(dut.s3), 64'(m3));
    u_ready = 1'b1;
    tick();
    chk("bp_consumed", 64'(u_valid), 64'd0);
    n = 1;
    while (!u_valid && n < 10) begin
      tick();
      n++;
    end
    chk("bp_gap", 64'(n), 64'd3);
    run_samples("bp_after", 5);
`ifdef TAUS_URNG_SAMPLE_CNT_EN
    chk("cnt_before_reload", 64'(sample_cnt), 64'd6);
`endif

    // Reload while a sample is being accepted: load wins
    chk("reload_pre_valid", 64'(u_valid), 64'd1);
    start(32'hDEADBEEF, 32'h0BADF00D);
    chk("reload_valid", 64'(u_valid), 64'd0);
    chk("reload_busy", 64'(busy), 64'd1);
`ifdef TAUS_URNG_SAMPLE_CNT_EN
    chk("reload_cnt", 64'(sample_cnt), 64'd0);
`endif
    wait_valid(n);
    chk("reload_latency", 64'(n), 64'd18);
    run_samples("reload", 5);

`ifdef TAUS_URNG_SAMPLE_CNT_EN
    chk("cnt_after_reload", 64'(sample_cnt), 64'd5);
    // Counter wrap: preset near the top, then two handshakes
    u_ready = 1'b0;
    force dut.sample_cnt = 32'hFFFFFFFE;
    #1;
    release dut.sample_cnt;
    u_ready = 1'b1;
    tick();
    chk("cnt_ffff", 64'(sample_cnt), 64'hFFFFFFFF);
    wait_valid(n);
    tick();
    chk("cnt_wrap", 64'(sample_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
